// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell evaluated per clock, LSB first, with a carry flop
// between bits. A start/done handshake frames each addition; sum/c_out hold the last result.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    // state | meaning
    // IDLE  | waiting for start; operands captured on the accepting edge
    // SHIFT | one bit per clock through the full-adder cell
    // DONE  | one-cycle done pulse; sum/c_out just updated
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_nxt;
    logic             carry;
    logic             carry_nxt;
    logic             s_bit;
    logic [CW-1:0]    cnt;
    logic             last;

    always_comb begin
        s_bit     = a_sr[0] ^ b_sr[0] ^ carry;
        carry_nxt = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
        // shift form keeps WIDTH=1 legal (no zero-width slices)
        psum_nxt  = (psum >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
        last      = (cnt == CW'(WIDTH - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= c_in;
                        psum  <= '0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    psum  <= psum_nxt;
                    carry <= carry_nxt;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        sum   <= psum_nxt;
                        c_out <= carry_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and randomized checks of bit_serial_adder at WIDTH=8 and WIDTH=1 against
// an arithmetic reference ({c_out,sum} = a + b + c_in).
module tb_bit_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, start1;
    logic [7:0] a8, b8;
    logic       cin8;
    logic [0:0] a1, b1;
    logic       cin1;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_sum;
    logic       exp_cout;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .c_in(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
    );

    bit_serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .c_in(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One full 8-bit addition: operands scrambled after capture, sum hold checked each busy cycle.
    task automatic run_add8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        logic [8:0] total;
        total = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            check("busy8_shift", {31'd0, busy8}, 32'd1);
            check("done8_shift", {31'd0, done8}, 32'd0);
            check("sum8_hold",   {24'd0, sum8},  {24'd0, exp_sum});
            check("cout8_hold",  {31'd0, cout8}, {31'd0, exp_cout});
        end
        @(negedge clk);
        exp_sum  = total[7:0];
        exp_cout = total[8];
        check("done8",  {31'd0, done8}, 32'd1);
        check("busy8_done", {31'd0, busy8}, 32'd0);
        check("sum8",   {24'd0, sum8},  {24'd0, exp_sum});
        check("cout8",  {31'd0, cout8}, {31'd0, exp_cout});
        @(negedge clk);
        check("done8_pulse", {31'd0, done8}, 32'd0);
        check("sum8_after",  {24'd0, sum8},  {24'd0, exp_sum});
    endtask

    initial begin
        int         done_cnt;
        logic [7:0] cap_sum;
        logic       cap_cout;
        logic [1:0] total1;

        rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        exp_sum = '0; exp_cout = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_busy8", {31'd0, busy8}, 32'd0);
        check("rst_done8", {31'd0, done8}, 32'd0);
        check("rst_sum8",  {24'd0, sum8},  32'd0);
        check("rst_cout8", {31'd0, cout8}, 32'd0);
        check("rst_busy1", {31'd0, busy1}, 32'd0);
        check("rst_sum1",  {31'd0, sum1},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // WIDTH=1: all eight full-adder combinations
        for (int n = 0; n < 8; n++) begin
            a1 = 1'(n >> 2); b1 = 1'(n >> 1); cin1 = 1'(n);
            total1 = 2'(a1) + 2'(b1) + 2'(cin1);
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            check("w1_busy", {31'd0, busy1}, 32'd1);
            check("w1_done_early", {31'd0, done1}, 32'd0);
            @(negedge clk);
            check("w1_done", {31'd0, done1}, 32'd1);
            check("w1_result", {30'd0, cout1, sum1}, {30'd0, total1});
            @(negedge clk);
            check("w1_done_pulse", {31'd0, done1}, 32'd0);
        end

        run_add8(8'h3C, 8'h42, 1'b0);
        check("t_3c42", {23'd0, cout8, sum8}, 32'h07E);
        run_add8(8'hFF, 8'h01, 1'b0);
        check("t_ff01", {23'd0, cout8, sum8}, 32'h100);
        run_add8(8'hA5, 8'h5A, 1'b1);
        check("t_a55a", {23'd0, cout8, sum8}, 32'h100);

        // start re-asserted on the 3rd busy cycle must be ignored
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        done_cnt = 0; cap_sum = 8'hXX; cap_cout = 1'bx;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done8) begin done_cnt++; cap_sum = sum8; cap_cout = cout8; end
            start8 = (c == 3);
            if (c == 3) begin a8 = 8'hFF; b8 = 8'hFF; end
        end
        check("ovl_done_count", done_cnt, 32'd1);
        check("ovl_sum",  {24'd0, cap_sum},  32'h30);
        check("ovl_cout", {31'd0, cap_cout}, 32'd0);
        exp_sum = 8'h30; exp_cout = 1'b0;

        // reset on the 4th busy cycle aborts the operation
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            check("abort_busy", {31'd0, busy8}, 32'd1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy0", {31'd0, busy8}, 32'd0);
        check("abort_done0", {31'd0, done8}, 32'd0);
        check("abort_sum0",  {24'd0, sum8},  32'd0);
        check("abort_cout0", {31'd0, cout8}, 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done8 || busy8) done_cnt++;
        end
        check("abort_no_done", done_cnt, 32'd0);
        exp_sum = '0; exp_cout = 1'b0;
        run_add8(8'h01, 8'h02, 1'b0);
        check("post_abort", {23'd0, cout8, sum8}, 32'h003);

        // reset and start on the same edge: start dropped
        a8 = 8'h11; b8 = 8'h22; start8 = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        start8 = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        check("rst_start_busy", {31'd0, busy8}, 32'd0);
        exp_sum = '0; exp_cout = 1'b0;

        for (int r = 0; r < 30; r++)
            run_add8(8'($urandom), 8'($urandom), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
